// File: rtl/tx_arbiter_pkg.sv
// Shared definitions for the UART transmit arbiter: FSM encoding and default timeout.
package tx_arb_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LOAD      = 2'd1,
        WAIT_LOW  = 2'd2,
        WAIT_HIGH = 2'd3
    } arb_state_t;

    localparam int TO_CYC_DEFAULT = 4;

endpackage

// File: rtl/tx_arbiter_rr_pick.sv
// Combinational rotate-priority picker: first asserted request strictly after last_ptr,
// wrapping modulo NREQ.
module rr_pick #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  last_ptr,
    output logic            any,
    output logic [IDW-1:0]  idx
);

    logic [NREQ-1:0] hi_mask;
    logic [NREQ-1:0] req_hi;
    logic [NREQ-1:0] cand;

    // Requests above last_ptr win; otherwise wrap to the lowest asserted index.
    always_comb begin
        hi_mask = '0;
        for (int i = 0; i < NREQ; i++) begin
            hi_mask[i] = (i > int'(last_ptr));
        end
        req_hi = req & hi_mask;
        cand   = (|req_hi) ? req_hi : req;
        idx    = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (cand[i]) idx = IDW'(i);
        end
        any = |req;
    end

endmodule

// File: rtl/tx_arbiter.sv
// Round-robin scheduler sharing one UART transmit engine among NREQ byte producers,
// with a sticky error when the engine never drops txrdy after a load.
module tx_arbiter
    import tx_arb_pkg::*;
#(
    parameter int NREQ   = 4,
    parameter int IDW    = 2,
    parameter int TO_CYC = TO_CYC_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ*8-1:0] req_data,
    output logic [NREQ-1:0]   ack,
    output logic              load,
    output logic [7:0]        out_port,
    input  logic              txrdy,
    output logic              busy,
    output logic [IDW-1:0]    grant_id,
    output logic              frame_done,
    output logic              err,
    input  logic              err_clr,
    output logic [1:0]        dbg_state
);

    localparam int CW = $clog2(TO_CYC + 1);

    // Handshake: a requester holds req/req_data until it sees its one-cycle ack pulse;
    // data is captured on that same edge, and dropping req earlier withdraws the byte.
    arb_state_t      state_q, state_d;
    logic [IDW-1:0]  last_ptr_q, last_ptr_d;
    logic [CW-1:0]   cnt_q, cnt_d, cnt_inc;
    logic [NREQ-1:0] ack_q, ack_d;
    logic            load_q, load_d;
    logic [7:0]      out_port_q, out_port_d;
    logic [IDW-1:0]  grant_id_q, grant_id_d;
    logic            frame_done_q, frame_done_d;
    logic            err_q, err_d;
    logic            timeout;

    logic            pick_any;
    logic [IDW-1:0]  pick_idx;

    rr_pick #(.NREQ(NREQ), .IDW(IDW)) u_pick (
        .req      (req),
        .last_ptr (last_ptr_q),
        .any      (pick_any),
        .idx      (pick_idx)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            last_ptr_q   <= IDW'(NREQ - 1);
            cnt_q        <= '0;
            ack_q        <= '0;
            load_q       <= 1'b0;
            out_port_q   <= '0;
            grant_id_q   <= '0;
            frame_done_q <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_ptr_q   <= last_ptr_d;
            cnt_q        <= cnt_d;
            ack_q        <= ack_d;
            load_q       <= load_d;
            out_port_q   <= out_port_d;
            grant_id_q   <= grant_id_d;
            frame_done_q <= frame_done_d;
            err_q        <= err_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        last_ptr_d   = last_ptr_q;
        cnt_d        = cnt_q;
        ack_d        = '0;
        load_d       = 1'b0;
        out_port_d   = out_port_q;
        grant_id_d   = grant_id_q;
        frame_done_d = 1'b0;
        timeout      = 1'b0;
        err_d        = err_q & ~err_clr;
        cnt_inc      = (cnt_q == CW'(TO_CYC)) ? cnt_q : cnt_q + 1'b1;

        case (state_q)
            IDLE: begin
                if (txrdy && pick_any) begin
                    for (int i = 0; i < NREQ; i++) begin
                        if (IDW'(i) == pick_idx) begin
                            ack_d[i]   = 1'b1;
                            out_port_d = req_data[i*8 +: 8];
                        end
                    end
                    grant_id_d = pick_idx;
                    state_d    = LOAD;
                end
            end
            LOAD: begin
                load_d  = 1'b1;
                cnt_d   = '0;
                state_d = WAIT_LOW;
            end
            WAIT_LOW: begin
                if (!txrdy) begin
                    state_d = WAIT_HIGH;
                end else begin
                    cnt_d = cnt_inc;
                    // Engine never accepted the byte: drop it and move on.
                    if (cnt_inc == CW'(TO_CYC)) begin
                        timeout    = 1'b1;
                        last_ptr_d = grant_id_q;
                        state_d    = IDLE;
                    end
                end
            end
            WAIT_HIGH: begin
                if (txrdy) begin
                    frame_done_d = 1'b1;
                    last_ptr_d   = grant_id_q;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (timeout) err_d = 1'b1;
    end

    assign ack        = ack_q;
    assign load       = load_q;
    assign out_port   = out_port_q;
    assign grant_id   = grant_id_q;
    assign frame_done = frame_done_q;
    assign err        = err_q;
    assign busy       = (state_q != IDLE);
    assign dbg_state  = state_q;

endmodule

// File: doc/tx_arbiter.md
Name: tx_arbiter

Overview:
Round-robin scheduler that shares the single UART transmit engine among NREQ byte producers. It accepts one byte per request via a valid/ack handshake and drives the engine's one-cycle load strobe and 8-bit data port. It tracks the engine's active-high ready flag through each frame, and flags a sticky error if the engine fails to respond.

Parameters:
NREQ, 4, number of requesters (2..8)
IDW, 2, width of grant_id (ceil(log2(NREQ)), min 1)
TO_CYC, 4, cycles allowed for txrdy to fall after load before error

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
req  in  NREQ  per-requester byte-valid, held until ack
req_data  in  NREQ*8  byte per requester; requester i uses bits [8i+7:8i]
ack  out  NREQ  one-hot, one-cycle pulse: byte taken from requester i
load  out  1  one-cycle load strobe to transmit engine
out_port  out  8  byte presented to transmit engine; stable from ack cycle through load cycle
txrdy  in  1  transmit engine ready (1 = idle)
busy  out  1  high in any state other than IDLE
grant_id  out  IDW  index of requester owning the current frame
frame_done  out  1  one-cycle pulse when the engine returns ready after a granted frame
err  out  1  sticky timeout flag
err_clr  in  1  synchronous clear of err

Behaviour:
- Reset (rst=0, async):
  - state=IDLE; ack=0, load=0, out_port=0, busy=0, grant_id=0, frame_done=0, err=0.
  - last_ptr=NREQ-1, so requester 0 has first priority.
- FSM states: IDLE, LOAD, WAIT_LOW, WAIT_HIGH.
- IDLE:
  - If txrdy=1 and |req: choose the first asserted req scanning from last_ptr+1, wrapping modulo NREQ.
  - Register req_data of the winner into out_port and its index into grant_id.
  - Pulse ack[winner] in the same edge; next state LOAD.
  - If txrdy=0, hold in IDLE; no ack is issued.
- LOAD: load=1 for exactly one cycle, then WAIT_LOW. Clear the timeout counter.
- WAIT_LOW:
  - The engine drops txrdy one cycle after load.
  - On txrdy=0, go to WAIT_HIGH.
  - Otherwise increment the timeout counter. When it reaches TO_CYC: set err=1, last_ptr=grant_id, return to IDLE. The byte is dropped, not retried.
- WAIT_HIGH:
  - On txrdy=1: pulse frame_done, set last_ptr=grant_id, go to IDLE.
  - No timeout here; frame length is set by the baud rate.
- Latency: ack in the cycle after sampling req; load 1 cycle after ack.
  - Next ack is no earlier than 1 cycle after frame_done.
- Handshake rules:
  - Requesters must hold req and req_data stable until ack.
  - Dropping req before ack withdraws the request.
  - Data is sampled only on the ack edge.
  - A requester may re-assert req in the cycle after its ack; it is then lowest priority.
- Simultaneous events:
  - err_clr and a timeout in the same cycle: the set wins.
  - req changes during non-IDLE states are ignored until IDLE.
- Arithmetic:
  - Pointer increment is modulo NREQ, not 2^IDW (matters when NREQ is not a power of 2).
  - Timeout counter is clog2(TO_CYC+1) bits and saturates.
- Reset mid-frame: the FSM aborts to IDLE with outputs at reset values, and the in-flight byte is lost. The engine shares the same reset.
- Only one ack per frame; ack and load are never high in the same cycle.

Decomposition:
- Package tx_arb_pkg: FSM state encoding (2-bit localparams IDLE=0, LOAD=1, WAIT_LOW=2, WAIT_HIGH=3) and the default TO_CYC constant.
- Sub-module rr_pick: combinational rotate-priority picker.
  - Inputs: req[NREQ], last_ptr.
  - Outputs: any, idx[IDW].
- FSM, pointer, timeout and output registers live in tx_arbiter.

Test Plan:
- Single requester: req=4'b0100, req_data[23:16]=8'hA5, txrdy=1 -> ack=4'b0100 next cycle, load one cycle later with out_port=8'hA5, grant_id=2. Engine model drops txrdy; frame_done pulses when txrdy returns.
- All four request continuously from reset -> grant order 0,1,2,3,0 with exactly one ack per frame, and no ack until frame_done of the prior frame.
- Fairness: after a frame granted to 2, req=4'b1001 -> requester 3 granted first, then 0.
- Engine stuck ready: txrdy held 1 after load -> err=1 exactly TO_CYC=4 cycles after the load cycle, FSM back to IDLE. Then err_clr=1 -> err=0.
- txrdy=0 while in IDLE with req=4'b0001 -> no ack and busy=0 until txrdy rises. Grant occurs the cycle after the rise.
- Assert rst=0 during WAIT_HIGH -> immediately load=0, busy=0, ack=0, out_port=0. After release, the first grant goes to requester 0.
